// File: rtl/mpmc11_rd_fifo_arb.sv
// rtl/mpmc11_rd_fifo_arb.sv - round-robin read-FIFO arbiter with registered grant
//
// Purpose: picks one readable command FIFO out of rd_req, offers it to the
// sequencer, pops it on acceptance and holds off further grants until the
// memory transaction completes.
//
// Optional feature macro: MPMC11_RD_ARB_AGE_EN adds per-port saturating
// starvation counters; a saturated requester overrides round-robin.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rd_req       [NPORT] readable FIFO candidate vector
//   grant_ack    sequencer accepts the current offer (OFFER only)
//   txn_done     sequencer finished the accepted transaction (BUSY only)
//   grant_valid  an offer is presented
//   grant_port   [PW] offered port index, 0 when no offer
//   grant_oh     [NPORT] one-hot offered port, 0 when no offer
//   fifo_rd      [NPORT] one-cycle pop strobe to the granted FIFO
//   busy         high in OFFER and BUSY

module mpmc11_rd_fifo_arb #(
    parameter int NPORT = 9,
    parameter int PW    = 4,
    parameter int AGE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] rd_req,
    input  logic             grant_ack,
    input  logic             txn_done,
    output logic             grant_valid,
    output logic [PW-1:0]    grant_port,
    output logic [NPORT-1:0] grant_oh,
    output logic [NPORT-1:0] fifo_rd,
    output logic             busy
);

    if ((2 ** PW) < NPORT || AGE_W < 1) begin : g_param_check
        $error("mpmc11_rd_fifo_arb: PW too narrow for NPORT or AGE_W < 1");
    end

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_OFFER = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_ptr_nxt;
    logic             grant_valid_nxt;
    logic [PW-1:0]    grant_port_nxt;
    logic [NPORT-1:0] grant_oh_nxt;
    logic [NPORT-1:0] fifo_rd_nxt;
    logic             busy_nxt;

    // Round-robin search: first requester at or above rr_ptr, wrapping.
    logic             rr_found;
    logic [PW-1:0]    rr_port;
    logic [NPORT-1:0] rr_shift;
    int               rr_cand;

    always_comb begin
        rr_found = 1'b0;
        rr_port  = '0;
        rr_shift = '0;
        rr_cand  = 0;
        for (int i = 0; i < NPORT; i++) begin
            rr_cand  = (int'(rr_ptr) + i) % NPORT;
            rr_shift = rd_req >> rr_cand;
            if (!rr_found && rr_shift[0]) begin
                rr_found = 1'b1;
                rr_port  = PW'(rr_cand);
            end
        end
    end

    logic [PW-1:0] sel_port;

`ifdef MPMC11_RD_ARB_AGE_EN
    logic [AGE_W-1:0] age [NPORT];
    logic             age_found;
    logic [PW-1:0]    age_port;

    // Lowest-index saturated requester wins; scan downward so the last hit is lowest.
    always_comb begin
        age_found = 1'b0;
        age_port  = '0;
        for (int i = NPORT - 1; i >= 0; i--) begin
            if (rd_req[i] && (age[i] == {AGE_W{1'b1}})) begin
                age_found = 1'b1;
                age_port  = PW'(i);
            end
        end
    end

    assign sel_port = age_found ? age_port : rr_port;

    // Ages move only on an ARB->OFFER transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NPORT; i++) begin
                age[i] <= '0;
            end
        end else if (state == ST_ARB && rr_found) begin
            for (int i = 0; i < NPORT; i++) begin
                if (sel_port == PW'(i)) begin
                    age[i] <= '0;
                end else if (rd_req[i] && (age[i] != {AGE_W{1'b1}})) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end
`else
    assign sel_port = rr_port;
`endif

    always_comb begin
        state_nxt       = state;
        rr_ptr_nxt      = rr_ptr;
        grant_valid_nxt = grant_valid;
        grant_port_nxt  = grant_port;
        grant_oh_nxt    = grant_oh;
        fifo_rd_nxt     = '0;
        case (state)
            ST_ARB: begin
                if (rr_found) begin
                    state_nxt       = ST_OFFER;
                    grant_valid_nxt = 1'b1;
                    grant_port_nxt  = sel_port;
                    grant_oh_nxt    = {{(NPORT-1){1'b0}}, 1'b1} << sel_port;
                end
            end
            ST_OFFER: begin
                // Offer is held regardless of rd_req; txn_done is not looked at here.
                if (grant_ack) begin
                    state_nxt       = ST_BUSY;
                    fifo_rd_nxt     = grant_oh;
                    rr_ptr_nxt      = (grant_port == PW'(NPORT - 1)) ? '0 : grant_port + 1'b1;
                    grant_valid_nxt = 1'b0;
                    grant_port_nxt  = '0;
                    grant_oh_nxt    = '0;
                end
            end
            ST_BUSY: begin
                if (txn_done) begin
                    state_nxt = ST_ARB;
                end
            end
            default: begin
                state_nxt       = ST_ARB;
                grant_valid_nxt = 1'b0;
                grant_port_nxt  = '0;
                grant_oh_nxt    = '0;
            end
        endcase
        busy_nxt = (state_nxt != ST_ARB);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_ARB;
            rr_ptr      <= '0;
            grant_valid <= 1'b0;
            grant_port  <= '0;
            grant_oh    <= '0;
            fifo_rd     <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_ptr_nxt;
            grant_valid <= grant_valid_nxt;
            grant_port  <= grant_port_nxt;
            grant_oh    <= grant_oh_nxt;
            fifo_rd     <= fifo_rd_nxt;
            busy        <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_mpmc11_rd_fifo_arb.sv
// tb/tb_mpmc11_rd_fifo_arb.sv - self-checking bench for mpmc11_rd_fifo_arb

module tb_mpmc11_rd_fifo_arb;

    localparam int NPORT = 9;
    localparam int PW    = 4;
    localparam int AGE_W = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [NPORT-1:0] rd_req = '0;
    logic             grant_ack = 1'b0;
    logic             txn_done = 1'b0;
    logic             grant_valid;
    logic [PW-1:0]    grant_port;
    logic [NPORT-1:0] grant_oh;
    logic [NPORT-1:0] fifo_rd;
    logic             busy;

    int n_pass = 0;
    int n_total = 0;

    mpmc11_rd_fifo_arb #(.NPORT(NPORT), .PW(PW), .AGE_W(AGE_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_req      (rd_req),
        .grant_ack   (grant_ack),
        .txn_done    (txn_done),
        .grant_valid (grant_valid),
        .grant_port  (grant_port),
        .grant_oh    (grant_oh),
        .fifo_rd     (fifo_rd),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Transaction-level model: phase 0 = idle, 1 = offer outstanding, 2 = waiting for done.
    int m_phase = 0;
    int m_ptr   = 0;
    int m_port  = 0;
    int m_pop   = -1;
    int m_age [NPORT];

    function automatic int pick_winner(input logic [NPORT-1:0] req);
        int w;
        w = -1;
`ifdef MPMC11_RD_ARB_AGE_EN
        for (int p = 0; p < NPORT; p++)
            if (w < 0 && req[p] && m_age[p] == (2 ** AGE_W) - 1) w = p;
`endif
        for (int k = 0; k < NPORT; k++)
            if (w < 0 && req[(m_ptr + k) % NPORT]) w = (m_ptr + k) % NPORT;
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_ptr = 0; m_port = 0; m_pop = -1;
            for (int p = 0; p < NPORT; p++) m_age[p] = 0;
        end else begin
            m_pop = -1;
            if (m_phase == 0) begin
                if (rd_req != 0) begin
                    m_port = pick_winner(rd_req);
                    for (int p = 0; p < NPORT; p++) begin
                        if (p == m_port) m_age[p] = 0;
                        else if (rd_req[p] && m_age[p] < (2 ** AGE_W) - 1) m_age[p]++;
                    end
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (grant_ack) begin
                    m_pop = m_port;
                    m_ptr = (m_port + 1) % NPORT;
                    m_phase = 2;
                end
            end else begin
                if (txn_done) m_phase = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("grant_valid", int'(grant_valid), (m_phase == 1) ? 1 : 0);
        check("grant_port", int'(grant_port), (m_phase == 1) ? m_port : 0);
        check("grant_oh", int'(grant_oh), (m_phase == 1) ? (1 << m_port) : 0);
        check("fifo_rd", int'(fifo_rd), (m_pop >= 0) ? (1 << m_pop) : 0);
        check("busy", int'(busy), (m_phase != 0) ? 1 : 0);
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant(output int port);
        for (int i = 0; i < 20 && grant_valid !== 1'b1; i++) step();
        check("grant_timeout", int'(grant_valid === 1'b1), 1);
        port = int'(grant_port);
    endtask

    task automatic txn(input logic [NPORT-1:0] req, input logic [NPORT-1:0] req_after,
                       input int stall, output int port);
        rd_req = req;
        wait_grant(port);
        rd_req = req_after;
        repeat (stall) step();
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        txn_done = 1'b1;
        step();
        txn_done = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gv"}, int'(grant_valid), 0);
        check({tag, "_gp"}, int'(grant_port), 0);
        check({tag, "_oh"}, int'(grant_oh), 0);
        check({tag, "_rd"}, int'(fifo_rd), 0);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int port;
        repeat (2) step();
        rst_n = 1'b1;
        // Idle with no requests.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_gv", int'(grant_valid), 0);
            check("idle_busy", int'(busy), 0);
        end
        // Full request vector: 0..8 then wrap to 0.
        for (int i = 0; i < 10; i++) begin
            txn(9'h1FF, 9'h1FF, 0, port);
            check("rr_seq", port, i % 9);
        end
        // Pointer now 1; grant 7 moves it to 8, then 9'h101 gives 8 then 0.
        txn(9'h080, 9'h000, 0, port);
        check("pre_wrap", port, 7);
        txn(9'h101, 9'h101, 0, port);
        check("wrap_hi", port, 8);
        txn(9'h101, 9'h000, 0, port);
        check("wrap_lo", port, 0);
        // Offer held while rd_req drops and ack is delayed.
        txn(9'h008, 9'h000, 5, port);
        check("stall_port", port, 3);
        // Reset while in OFFER.
        rd_req = 9'h020;
        wait_grant(port);
        check("pre_rst_offer", port, 5);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_offer");
        rd_req = '0;
        step();
        rst_n = 1'b1;
        txn(9'h1FF, 9'h1FF, 0, port);
        check("after_rst_offer", port, 0);
        // Reset while in BUSY with the pop strobe high.
        rd_req = 9'h040;
        wait_grant(port);
        grant_ack = 1'b1;
        step();
        grant_ack = 1'b0;
        check("busy_pop", int'(fifo_rd), 9'h040);
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_busy");
        step();
        rst_n = 1'b1;
        txn(9'h1FF, 9'h000, 0, port);
        check("after_rst_busy", port, 0);
        // Randomized phase checked by the per-cycle model compare.
        for (int i = 0; i < 3000; i++) begin
            rd_req    = NPORT'($urandom);
            grant_ack = ($urandom_range(0, 2) == 0);
            txn_done  = ($urandom_range(0, 2) == 0);
            rst_n     = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n = 1'b1;
        rd_req = '0;
        grant_ack = 1'b0;
        txn_done = 1'b0;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
